// File: rtl/alu_pkg.sv
// Shared opcode constants, instruction field positions and FSM encoding for the ALU issue stage.
`timescale 1ns/1ps
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_EPAR   = 4'b0101;

    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned EQ_BIT   = 11;
    localparam int unsigned LTGT_MSB = 10;
    localparam int unsigned LTGT_LSB = 8;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned RD_MSB   = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StResp   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational instruction decode: field extraction, opcode legality and immediate sign-extension.
`timescale 1ns/1ps
module alu_instr_decode
    import alu_pkg::*;
(
    input  logic [15:0] in_instr,
    output logic [3:0]  o_op,
    output logic        o_eq,
    output logic [2:0]  o_ltgt,
    output logic [2:0]  o_rd,
    output logic [15:0] o_imm_sext,
    output logic        o_legal,
    output logic        o_is_branch
);

    logic [7:0] w_imm;

    always_comb begin
        o_op        = in_instr[OP_MSB:OP_LSB];
        o_eq        = in_instr[EQ_BIT];
        o_ltgt      = in_instr[LTGT_MSB:LTGT_LSB];
        w_imm       = in_instr[IMM_MSB:0];
        o_rd        = w_imm[RD_MSB:0];
        o_imm_sext  = {{8{w_imm[7]}}, w_imm};
        o_is_branch = (o_op == OP_BRANCH);
        o_legal     = (o_op == OP_ADD) || (o_op == OP_EPAR) || (o_op == OP_BRANCH);
    end

endmodule

// File: rtl/alu_issue.sv
// Issues one instruction at a time to an external combinational ALU and returns a write-back
// or branch response; illegal opcodes are consumed with a one-cycle err pulse.
`timescale 1ns/1ps
module alu_issue
    import alu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [15:0] in_pc,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_res,
    output logic [15:0] alu_register,
    output logic [2:0]  alu_ltgt,
    output logic        alu_eq,
    input  logic [15:0] alu_out,
    input  logic        alu_compres,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_br,
    output logic [2:0]  out_rd,
    output logic [15:0] out_data,
    output logic        out_taken,
    output logic        err,
    output logic [15:0] cnt_done
);

    state_t      r_state;
    logic [3:0]  r_op;
    logic        r_eq;
    logic [2:0]  r_ltgt;
    logic [2:0]  r_rd;
    logic [15:0] r_a, r_b, r_pc, r_imm_sext;
    logic        r_is_br;
    logic        r_out_br, r_out_taken, r_err;
    logic [2:0]  r_out_rd;
    logic [15:0] r_out_data, r_cnt;

    logic [3:0]  w_op;
    logic        w_eq, w_legal, w_is_br, w_drive;
    logic [2:0]  w_ltgt, w_rd;
    logic [15:0] w_imm_sext, w_pc_next, w_target;

    alu_instr_decode u_decode (
        .in_instr    (in_instr),
        .o_op        (w_op),
        .o_eq        (w_eq),
        .o_ltgt      (w_ltgt),
        .o_rd        (w_rd),
        .o_imm_sext  (w_imm_sext),
        .o_legal     (w_legal),
        .o_is_branch (w_is_br)
    );

    // ALU inputs are only presented while an instruction is in flight; zero otherwise.
    assign w_drive      = (r_state == StDrive) || (r_state == StSample);
    assign alu_op       = w_drive ? r_op : 4'd0;
    assign alu_eq       = w_drive ? r_eq : 1'b0;
    assign alu_ltgt     = w_drive ? r_ltgt : 3'd0;
    assign alu_res      = w_drive ? r_a : 16'd0;
    assign alu_register = w_drive ? r_b : 16'd0;

    assign w_pc_next = r_pc + 16'd1;
    assign w_target  = w_pc_next + r_imm_sext;

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StResp);
    assign out_br    = r_out_br;
    assign out_rd    = r_out_rd;
    assign out_data  = r_out_data;
    assign out_taken = r_out_taken;
    assign err       = r_err;
    assign cnt_done  = r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_op        <= 4'd0;
            r_eq        <= 1'b0;
            r_ltgt      <= 3'd0;
            r_rd        <= 3'd0;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_pc        <= 16'd0;
            r_imm_sext  <= 16'd0;
            r_is_br     <= 1'b0;
            r_out_br    <= 1'b0;
            r_out_rd    <= 3'd0;
            r_out_data  <= 16'd0;
            r_out_taken <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= 16'd0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        if (w_legal) begin
                            r_op       <= w_op;
                            r_eq       <= w_eq;
                            r_ltgt     <= w_ltgt;
                            r_rd       <= w_rd;
                            r_a        <= in_a;
                            r_b        <= in_b;
                            r_pc       <= in_pc;
                            r_imm_sext <= w_imm_sext;
                            r_is_br    <= w_is_br;
                            r_state    <= StDrive;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StDrive: r_state <= StSample;
                StSample: begin
                    r_out_br    <= r_is_br;
                    r_out_rd    <= r_is_br ? 3'd0 : r_rd;
                    r_out_taken <= r_is_br && alu_compres;
                    if (r_is_br) r_out_data <= alu_compres ? w_target : w_pc_next;
                    else         r_out_data <= alu_out;
                    r_state <= StResp;
                end
                StResp: begin
                    if (out_ready) begin
                        r_cnt       <= r_cnt + 16'd1;
                        r_out_br    <= 1'b0;
                        r_out_rd    <= 3'd0;
                        r_out_data  <= 16'd0;
                        r_out_taken <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU attached to the alu_* bus.
`timescale 1ns/1ps
module tb_alu_issue;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr, in_a, in_b, in_pc;
    logic [3:0]  alu_op;
    logic [15:0] alu_res, alu_register, alu_out;
    logic [2:0]  alu_ltgt;
    logic        alu_eq, alu_compres;
    logic        out_valid, out_ready, out_br, out_taken, err;
    logic [2:0]  out_rd;
    logic [15:0] out_data, cnt_done;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clock = ~clock;

    alu_issue dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_pc        (in_pc),
        .alu_op       (alu_op),
        .alu_res      (alu_res),
        .alu_register (alu_register),
        .alu_ltgt     (alu_ltgt),
        .alu_eq       (alu_eq),
        .alu_out      (alu_out),
        .alu_compres  (alu_compres),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_br       (out_br),
        .out_rd       (out_rd),
        .out_data     (out_data),
        .out_taken    (out_taken),
        .err          (err),
        .cnt_done     (cnt_done)
    );

    // External ALU model: add/sub selected by eq, parity, and eq/lt/gt compare.
    always_comb begin
        alu_out = 16'd0;
        case (alu_op)
            4'b0000: alu_out = alu_eq ? alu_res + alu_register : alu_res - alu_register;
            4'b0101: alu_out = {15'd0, ^alu_res};
            default: alu_out = 16'd0;
        endcase
        alu_compres = (alu_eq && (alu_res == alu_register)) ||
                      (alu_ltgt[2] && (alu_res < alu_register)) ||
                      (alu_ltgt[0] && (alu_res > alu_register));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction from an idle state; returns #1 after the accept edge.
    task automatic send(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] pc);
        chk("ready_pre", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_instr = instr;
        in_a     = a;
        in_b     = b;
        in_pc    = pc;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
    endtask

    // Walk DRIVE and SAMPLE, then check the response fields in RESP.
    task automatic expect_resp(input string tag, input logic [3:0] op, input logic [15:0] a,
                               input logic br, input logic [2:0] rd, input logic [15:0] data,
                               input logic taken);
        chk({tag, "_drv_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_drv_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_drv_op"}, {28'd0, alu_op}, {28'd0, op});
        chk({tag, "_drv_res"}, {16'd0, alu_res}, {16'd0, a});
        @(posedge clock);
        #1;
        chk({tag, "_smp_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_smp_op"}, {28'd0, alu_op}, {28'd0, op});
        @(posedge clock);
        #1;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_br"}, {31'd0, out_br}, {31'd0, br});
        chk({tag, "_rd"}, {29'd0, out_rd}, {29'd0, rd});
        chk({tag, "_data"}, {16'd0, out_data}, {16'd0, data});
        chk({tag, "_taken"}, {31'd0, out_taken}, {31'd0, taken});
        chk({tag, "_resp_op"}, {28'd0, alu_op}, 32'd0);
    endtask

    task automatic finish_xfer(input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, "_cnt"}, {16'd0, cnt_done}, {16'd0, exp_cnt});
        chk({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 16'd0;
        in_a      = 16'd0;
        in_b      = 16'd0;
        in_pc     = 16'd0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_done}, 32'd0);
        chk("rst_op", {28'd0, alu_op}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        send({4'h0, 1'b1, 3'd0, 8'h05}, 16'd5, 16'd7, 16'h0100);
        expect_resp("add", 4'h0, 16'd5, 1'b0, 3'd5, 16'd12, 1'b0);
        finish_xfer("add");

        send({4'h0, 1'b0, 3'd0, 8'h03}, 16'd10, 16'd3, 16'h0101);
        expect_resp("sub", 4'h0, 16'd10, 1'b0, 3'd3, 16'd7, 1'b0);
        finish_xfer("sub");

        send({4'h5, 1'b0, 3'd0, 8'h02}, 16'h0007, 16'h0000, 16'h0102);
        expect_resp("par", 4'h5, 16'h0007, 1'b0, 3'd2, 16'd1, 1'b0);
        finish_xfer("par");

        send({4'h4, 1'b1, 3'd0, 8'hFE}, 16'h0042, 16'h0042, 16'h0010);
        expect_resp("br_t", 4'h4, 16'h0042, 1'b1, 3'd0, 16'h000F, 1'b1);
        finish_xfer("br_t");

        send({4'h4, 1'b1, 3'd0, 8'h01}, 16'h0001, 16'h0002, 16'hFFFF);
        expect_resp("br_nt", 4'h4, 16'h0001, 1'b1, 3'd0, 16'h0000, 1'b0);
        finish_xfer("br_nt");

        // Back-pressure: response must hold while out_ready stays low.
        out_ready = 1'b0;
        send({4'h0, 1'b1, 3'd0, 8'h06}, 16'h1234, 16'h0101, 16'h0200);
        expect_resp("hold", 4'h0, 16'h1234, 1'b0, 3'd6, 16'h1335, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {16'd0, out_data}, 32'h1335);
            chk("hold_rd", {29'd0, out_rd}, 32'd6);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_cnt", {16'd0, cnt_done}, {16'd0, exp_cnt});
        end
        finish_xfer("hold");

        // Illegal opcode: consumed, one-cycle err, no response.
        send({4'h7, 1'b0, 3'd0, 8'h01}, 16'd1, 16'd2, 16'h0300);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_ready", {31'd0, in_ready}, 32'd1);
        chk("ill_op", {28'd0, alu_op}, 32'd0);
        @(posedge clock);
        #1;
        chk("ill_err_low", {31'd0, err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ill_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clock);
            #1;
        end
        chk("ill_cnt", {16'd0, cnt_done}, {16'd0, exp_cnt});

        // Reset while in SAMPLE discards the instruction.
        send({4'h0, 1'b1, 3'd0, 8'h04}, 16'd9, 16'd9, 16'h0400);
        @(posedge clock);
        #1;
        chk("mid_smp_op", {28'd0, alu_op}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_cnt = 16'd0;
        chk("mid_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_data", {16'd0, out_data}, 32'd0);
        chk("mid_res", {16'd0, alu_res}, 32'd0);
        chk("mid_cnt", {16'd0, cnt_done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            chk("mid_no_resp", {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
